sar_frontend: RTL and testbench
===============================

# sar_frontend

Behavioral front end that sits opposite the SAR conversion controller: it samples a digital stand-in for the analog input, holds it, and answers each DAC trial code with a comparator decision. It then checks the controller's final code against the held sample. The block lets the SAR controller run closed-loop in simulation and FPGA self-test, and it reports conversion count, match and protocol errors.

## Interface
- `WIDTH`, 4: sample/DAC code width in bits.
- `CMP_LAT`, 1: comparator latency in cycles, legal 1..4.
- `clock`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-high.
- `sample_in`  in  WIDTH  value to be converted; latched on accepted `start`.
- `start`  in  1  request a new sample/hold.
- `dac_code`  in  WIDTH  trial code from the SAR controller.
- `trial_valid`  in  1  `dac_code` is a new trial this cycle.
- `result`  in  WIDTH  final code from the controller.
- `result_valid`  in  1  `result` is final this cycle.
- `busy`  out  1  high in HOLD.
- `held`  out  WIDTH  held sample.
- `cmp`  out  1  comparator decision: 1 when `held >= trial code`.
- `cmp_valid`  out  1  `cmp` is valid this cycle.
- `done`  out  1  one-cycle pulse when a result is checked.
- `match`  out  1  last checked result was within tolerance; updated with `done`.
- `overrun`  out  1  sticky; more than WIDTH trials in the current conversion.
- `conv_count`  out  16  number of checked conversions.

## Operation
- States:
  - IDLE: `start` latches `sample_in` into `held`, clears the trial counter and `overrun`, then goes to HOLD. `trial_valid` and `result_valid` are ignored.
  - HOLD: each `trial_valid` is captured into the comparator pipeline (`sar_cmp_pipe`) as `held >= dac_code` and increments the trial counter. `start` is ignored. `result_valid` goes to CHECK.
  - CHECK: one cycle long. Asserts `done`, updates `match`, increments `conv_count` with 16-bit wrap, flushes the pipeline, then returns to IDLE.
- Trial counter: the WIDTH+1st and later trials set `overrun`. They are still answered.
- `trial_valid` and `result_valid` in the same HOLD cycle: the result wins, the trial is dropped and not counted.
- Tolerance:
  - Without dither, `match` = (`result == held`).
  - With dither, `match` = |`result - held`| <= 1, computed unsigned with WIDTH+1 bits.
- Comparisons are unsigned.

## Timing
- Reset values: state IDLE, `busy`=0, `held`=0, `cmp`=0, `cmp_valid`=0, `done`=0, `match`=0, `overrun`=0, `conv_count`=0. Reset also flushes the pipeline and takes effect mid-conversion.
- `start` at edge t gives `busy`=1 and valid `held` from t+1. The first trial is accepted at t+1 at the earliest.
- A trial accepted at edge t gives `cmp`/`cmp_valid` at cycle t+CMP_LAT. This holds back to back, one decision per cycle.
- `result_valid` at edge t gives `done`=1, `busy`=1 and updated `match` at t+1. At t+2 the state is IDLE with `busy`=0.
- Pipeline entries still in flight when CHECK is entered are discarded and never assert `cmp_valid`.

## Configuration
- `SAR_FE_DITHER_EN` defined:
  - An 8-bit Fibonacci LFSR (seed 8'hA5 on reset, advancing every cycle) replaces the comparator decision with the LFSR LSB when `held == dac_code`. This models comparator indecision at threshold.
  - Match tolerance is ±1 LSB.
- Not defined:
  - The decision is exact and tolerance is 0.
  - No LFSR logic is present.

## Structure
- Package `sar_pkg` holds:
  - the state typedef (IDLE, HOLD, CHECK);
  - the LFSR seed and tap constants;
  - the `conv_count` width constant.
- Sub-module `sar_cmp_pipe` is a CMP_LAT-deep valid/data shift register with synchronous flush.

## Test plan
- WIDTH=4, CMP_LAT=1: `sample_in`=4'd11, `start`, then trials 8, 12, 10, 11 → `cmp` = 1, 0, 1, 1, each one cycle after its trial. `result`=11 → `done`, `match`=1, `conv_count`=1.
- `result`=4'd9 with `held`=4'd11 → `match`=0; without dither `match`=0 also for `result`=10.
- Five trials before `result_valid` → `overrun`=1 after the fifth. The next `start` clears it.
- CMP_LAT=3, four back-to-back trials → four consecutive `cmp_valid` cycles starting 3 cycles after the first trial. `result_valid` asserted before the last one emerges → the remaining decision is suppressed.
- `rst` asserted during HOLD → next cycle all outputs equal reset values and `start` is accepted immediately after.
- With `SAR_FE_DITHER_EN`: `held`=7, trial 7 repeated → `cmp` follows the LFSR LSB sequence from seed 8'hA5. `result`=6 → `match`=1.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: shared FSM state type and constants for the SAR front end.
package sar_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, CHECK} sar_state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int CONV_W = 16;
endpackage

// File: rtl/sar_cmp_pipe.sv
// sar_cmp_pipe: LAT-deep valid/data shift register with synchronous flush.
module sar_cmp_pipe #(
  parameter int LAT = 1
) (
  input  logic clock,
  input  logic rst,
  input  logic flush_i,
  input  logic valid_i,
  input  logic data_i,
  output logic valid_o,
  output logic data_o
);
  logic [LAT-1:0] valid_q;
  logic [LAT-1:0] data_q;
  always_ff @(posedge clock) begin
    if (rst || flush_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end
  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];
endmodule

// File: rtl/sar_frontend.sv
// sar_frontend: sample/hold plus comparator model answering SAR trials and checking results.
// Define SAR_FE_DITHER_EN for LFSR decisions at threshold and +/-1 LSB result tolerance.
module sar_frontend import sar_pkg::*; #(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              start,
  input  logic [WIDTH-1:0]  dac_code,
  input  logic              trial_valid,
  input  logic [WIDTH-1:0]  result,
  input  logic              result_valid,
  output logic              busy,
  output logic [WIDTH-1:0]  held,
  output logic              cmp,
  output logic              cmp_valid,
  output logic              done,
  output logic              match,
  output logic              overrun,
  output logic [CONV_W-1:0] conv_count
);
  localparam int CW = $clog2(WIDTH + 2);
  sar_state_t state_q, state_d;
  logic [WIDTH-1:0] held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic overrun_q, overrun_d, match_q, match_d;
  logic [CONV_W-1:0] conv_q, conv_d;
  logic trial_acc, flush, decision, tol_ok;
`ifdef SAR_FE_DITHER_EN
  logic [7:0] lfsr_q;
  logic [WIDTH:0] diff;
  always_ff @(posedge clock) lfsr_q <= rst ? LFSR_SEED : {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  // At threshold the comparator is undecided; the LFSR stands in for noise.
  assign decision = (held_q == dac_code) ? lfsr_q[0] : (held_q >= dac_code);
  assign diff = {1'b0, result} - {1'b0, held_q};
  assign tol_ok = (diff == '0) || (diff == (WIDTH+1)'(1)) || (diff == '1);
`else
  assign decision = held_q >= dac_code;
  assign tol_ok = result == held_q;
`endif
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    match_d   = match_q;
    conv_d    = conv_q;
    trial_acc = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        held_d    = sample_in;
        cnt_d     = '0;
        overrun_d = 1'b0;
        state_d   = HOLD;
      end
      HOLD: if (result_valid) begin
        state_d = CHECK;
        flush   = 1'b1;
        match_d = tol_ok;
        conv_d  = conv_q + 1'b1;
      end else if (trial_valid) begin
        trial_acc = 1'b1;
        cnt_d     = (cnt_q > CW'(WIDTH)) ? cnt_q : cnt_q + 1'b1;
        overrun_d = overrun_q || (cnt_q >= CW'(WIDTH));
      end
      CHECK: begin
        state_d = IDLE;
        flush   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= IDLE;
      held_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      match_q   <= 1'b0;
      conv_q    <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      match_q   <= match_d;
      conv_q    <= conv_d;
    end
  end
  sar_cmp_pipe #(.LAT(CMP_LAT)) u_pipe (
    .clock   (clock),
    .rst     (rst),
    .flush_i (flush),
    .valid_i (trial_acc),
    .data_i  (decision),
    .valid_o (cmp_valid),
    .data_o  (cmp)
  );
  assign busy       = state_q != IDLE;
  assign done       = state_q == CHECK;
  assign held       = held_q;
  assign match      = match_q;
  assign overrun    = overrun_q;
  assign conv_count = conv_q;
endmodule

// File: tb/tb_sar_frontend.sv
// tb_sar_frontend: directed checks of sar_frontend at comparator latencies 1 and 3.
module tb_sar_frontend;
  logic clock = 1'b0;
  logic rst, start, trial_valid, result_valid;
  logic [3:0] sample_in, dac_code, result;
  logic busy, cmp, cmp_valid, done, match, overrun;
  logic [3:0] held;
  logic [15:0] conv_count;
  logic busy3, cmp3, cmp_valid3, done3, match3, overrun3;
  logic [3:0] held3;
  logic [15:0] conv_count3;
  int errors = 0;
  int checks = 0;
  always #5 clock = ~clock;
  sar_frontend #(.WIDTH(4), .CMP_LAT(1)) dut (
    .clock(clock), .rst(rst), .sample_in(sample_in), .start(start),
    .dac_code(dac_code), .trial_valid(trial_valid), .result(result),
    .result_valid(result_valid), .busy(busy), .held(held), .cmp(cmp),
    .cmp_valid(cmp_valid), .done(done), .match(match), .overrun(overrun),
    .conv_count(conv_count)
  );
  sar_frontend #(.WIDTH(4), .CMP_LAT(3)) dut3 (
    .clock(clock), .rst(rst), .sample_in(sample_in), .start(start),
    .dac_code(dac_code), .trial_valid(trial_valid), .result(result),
    .result_valid(result_valid), .busy(busy3), .held(held3), .cmp(cmp3),
    .cmp_valid(cmp_valid3), .done(done3), .match(match3), .overrun(overrun3),
    .conv_count(conv_count3)
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " held"}, 32'(held), 0);
    chk({tag, " cmp"}, 32'(cmp), 0);
    chk({tag, " cmp_valid"}, 32'(cmp_valid), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " match"}, 32'(match), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " conv_count"}, 32'(conv_count), 0);
    chk({tag, " cmp_valid3"}, 32'(cmp_valid3), 0);
  endtask
  initial begin
    rst = 1; start = 0; trial_valid = 0; result_valid = 0;
    sample_in = 0; dac_code = 0; result = 0;
    tick(); tick();
    chk_reset("reset");
    rst = 0;
    // conversion 1: held 11, trials 8,12,10,11
    sample_in = 4'd11; start = 1; tick(); start = 0;
    chk("c1 busy", 32'(busy), 1);
    chk("c1 held", 32'(held), 11);
    trial_valid = 1;
    dac_code = 4'd8;  tick(); chk("c1 t8 cmp", 32'({cmp_valid, cmp}), 3);  chk("c1 t8 v3", 32'(cmp_valid3), 0);
    dac_code = 4'd12; tick(); chk("c1 t12 cmp", 32'({cmp_valid, cmp}), 2); chk("c1 t12 v3", 32'(cmp_valid3), 0);
    dac_code = 4'd10; tick(); chk("c1 t10 cmp", 32'({cmp_valid, cmp}), 3); chk("c1 l3 t8", 32'({cmp_valid3, cmp3}), 3);
    dac_code = 4'd11; tick(); chk("c1 t11 cmp", 32'({cmp_valid, cmp}), 3); chk("c1 l3 t12", 32'({cmp_valid3, cmp3}), 2);
    trial_valid = 0; result = 4'd11; result_valid = 1; tick(); result_valid = 0;
    chk("c1 done", 32'(done), 1);
    chk("c1 busy check", 32'(busy), 1);
    chk("c1 match", 32'(match), 1);
    chk("c1 conv_count", 32'(conv_count), 1);
    chk("c1 cmp_valid after", 32'(cmp_valid), 0);
    chk("c1 l3 flushed a", 32'(cmp_valid3), 0);
    tick();
    chk("c1 idle done", 32'(done), 0);
    chk("c1 idle busy", 32'(busy), 0);
    chk("c1 l3 flushed b", 32'(cmp_valid3), 0);
    // conversion 2: result 9 vs held 11
    start = 1; tick(); start = 0;
    result = 4'd9; result_valid = 1; tick(); result_valid = 0;
    chk("c2 done", 32'(done), 1);
    chk("c2 match", 32'(match), 0);
    chk("c2 conv_count", 32'(conv_count), 2);
    tick();
    // conversion 3: result 10 vs held 11, exact tolerance
    start = 1; tick(); start = 0;
    result = 4'd10; result_valid = 1; tick(); result_valid = 0;
    chk("c3 match", 32'(match), 0);
    chk("c3 conv_count", 32'(conv_count), 3);
    tick();
    // conversion 4: held 5, five trials, overrun, latency-3 stream
    sample_in = 4'd5; start = 1; tick(); start = 0;
    chk("c4 held", 32'(held), 5);
    chk("c4 overrun clear", 32'(overrun), 0);
    trial_valid = 1;
    dac_code = 4'd3;  tick(); chk("c4 t3", 32'({cmp_valid, cmp}), 3);
    dac_code = 4'd5;  tick(); chk("c4 t5", 32'({cmp_valid, cmp}), 3);
    dac_code = 4'd6;  tick(); chk("c4 t6", 32'({cmp_valid, cmp}), 2);  chk("c4 l3 a", 32'({cmp_valid3, cmp3}), 3);
    dac_code = 4'd0;  tick(); chk("c4 t0", 32'({cmp_valid, cmp}), 3);  chk("c4 l3 b", 32'({cmp_valid3, cmp3}), 3);
    chk("c4 overrun after 4", 32'(overrun), 0);
    dac_code = 4'd15; tick(); chk("c4 t15", 32'({cmp_valid, cmp}), 2); chk("c4 l3 c", 32'({cmp_valid3, cmp3}), 2);
    chk("c4 overrun after 5", 32'(overrun), 1);
    trial_valid = 0;
    tick(); chk("c4 idle cmp_valid", 32'(cmp_valid), 0); chk("c4 l3 d", 32'({cmp_valid3, cmp3}), 3);
    tick(); chk("c4 l3 e", 32'({cmp_valid3, cmp3}), 2);
    tick(); chk("c4 l3 drained", 32'(cmp_valid3), 0);
    trial_valid = 1; dac_code = 4'd1; result = 4'd5; result_valid = 1; tick();
    trial_valid = 0; result_valid = 0;
    chk("c4 done", 32'(done), 1);
    chk("c4 match", 32'(match), 1);
    chk("c4 conv_count", 32'(conv_count), 4);
    chk("c4 dropped trial", 32'(cmp_valid), 0);
    tick();
    chk("c4 overrun sticky", 32'(overrun), 1);
    sample_in = 4'd2; start = 1; tick(); start = 0;
    chk("c5 overrun cleared", 32'(overrun), 0);
    chk("c5 held", 32'(held), 2);
    // reset during HOLD
    trial_valid = 1; dac_code = 4'd1; tick(); trial_valid = 0;
    chk("c5 t1", 32'({cmp_valid, cmp}), 3);
    rst = 1; tick(); rst = 0;
    chk_reset("midrst");
    sample_in = 4'd9; start = 1; tick(); start = 0;
    chk("post rst busy", 32'(busy), 1);
    chk("post rst held", 32'(held), 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
